pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter ALUOP_W, default 8, ALU/memory op code width.
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter RADDR_W, default 5, destination register index width.
REQ-004 SHALL have parameter DATA_W, default 32, write-back data width.
REQ-005 SHALL have parameter STALL_W, default 6, stall vector width.
REQ-006 SHALL have parameter STALL_IDX, default 3, stall bit owned by this stage.
REQ-007 SHALL have parameter NOP_ALUOP, default 0, op code inserted as a bubble.
REQ-008 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-009 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port in_valid, input, 1, upstream payload valid.
REQ-011 SHALL have port in_ready, output, 1, stage can accept.
REQ-012 SHALL have ports in_aluop/in_addr/in_wd/in_wreg/in_wdata, input, ALUOP_W/ADDR_W/RADDR_W/1/DATA_W, upstream payload.
REQ-013 SHALL have port stall_state, input, STALL_W, global stall vector.
REQ-014 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-015 SHALL have port out_valid, output, 1, downstream payload valid.
REQ-016 SHALL have port out_ready, input, 1, downstream can take payload.
REQ-017 SHALL have ports out_aluop/out_addr/out_wd/out_wreg/out_wdata, output, same widths as REQ-012, downstream payload.
REQ-018 SHALL have port occupancy, output, 2, held entry count (0..2).

Function
REQ-019 SHALL hold two entries: main (drives out_*) and skid; skid valid only when main valid; FIFO order preserved.
REQ-020 SHALL drive in_ready directly from a register, equal to NOT skid_valid.
REQ-021 SHALL accept when in_valid AND in_ready AND NOT flush; payload fields are captured unchanged.
REQ-022 SHALL drain when out_valid AND out_ready AND stall_state[STALL_IDX]==0; a set stall bit blocks draining and holds all outputs stable.
REQ-023 Stall SHALL NOT block accepting while in_ready=1 (a skid slot is free).
REQ-024 Main empty plus accept SHALL load main; out_valid=1 on the next cycle (latency 1).
REQ-025 Main full plus drain plus accept SHALL load main from in; skid remains empty.
REQ-026 Main full, no drain, accept SHALL load skid; in_ready=0 on the next cycle.
REQ-027 Skid full plus drain SHALL move skid to main and clear skid; in_ready=1 on the next cycle.
REQ-028 While main is empty, out_* SHALL present a bubble: aluop=NOP_ALUOP, addr=0, wd=0, wreg=0, wdata=0, out_valid=0.
REQ-029 Flush SHALL clear both entries on the next edge; outputs become a bubble; a simultaneous accept or drain is discarded; flush takes priority over stall.
REQ-030 occupancy SHALL equal main_valid + skid_valid, registered.

Reset
REQ-031 rst low SHALL immediately clear main and skid and set out_valid=0, out_* to a bubble, occupancy=0, and in_ready=1.
REQ-032 Reset asserted mid-transfer SHALL discard held entries with no partial state; the first accept after release behaves per REQ-024.

Verification
REQ-033 Empty stage, in_valid=1 with aluop=0x12, addr=0x1000, wd=5, wreg=1, wdata=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1 with identical fields; occupancy=1.
REQ-034 out_ready=0, three back-to-back inputs A,B,C -> A in main, B in skid, in_ready=0, C held upstream; release out_ready -> outputs A,B,C in order with no loss.
REQ-035 Main=A, stall_state[3]=1, out_ready=1 for 4 cycles -> out_* frozen at A; B accepted into skid; stall cleared -> A then B drained.
REQ-036 occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_aluop=NOP_ALUOP, in_ready=1, input discarded.
REQ-037 occupancy=2, rst driven low between clock edges -> outputs go to a bubble without waiting for an edge; after release, a single input appears after 1 cycle.
REQ-038 Parameters DATA_W=64, RADDR_W=6 -> REQ-033 passes with wdata=0x0123456789ABCDEF, wd=33.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (main + skid) with registered in_ready.
// main drives the outputs; skid absorbs one extra beat when the consumer
// cannot take data, so in_ready never depends combinationally on out_ready.
module pipe_stage_buf #(
  parameter int unsigned ALUOP_W   = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RADDR_W   = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STALL_IDX = 3,
  parameter int unsigned NOP_ALUOP = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [RADDR_W-1:0] in_wd,
  input  logic               in_wreg,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [STALL_W-1:0] stall_state,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [RADDR_W-1:0] out_wd,
  output logic               out_wreg,
  output logic [DATA_W-1:0]  out_wdata,
  output logic [1:0]         occupancy
);

  localparam int unsigned PayW = ALUOP_W + ADDR_W + RADDR_W + 1 + DATA_W;
  localparam logic [ALUOP_W-1:0] NopOp = ALUOP_W'(NOP_ALUOP);
  localparam logic [PayW-1:0] Bubble = {NopOp, {(PayW - ALUOP_W){1'b0}}};

  logic [PayW-1:0] in_pay;
  logic [PayW-1:0] main_q, main_d;
  logic [PayW-1:0] skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  logic [1:0]      occ_q, occ_d;
  logic            accept;
  logic            drain;

  assign in_pay = {in_aluop, in_addr, in_wd, in_wreg, in_wdata};

  // Stall only blocks draining; accepting is gated by the free skid slot alone.
  assign accept = in_valid & in_ready_q & ~flush;
  assign drain  = main_valid_q & out_ready & ~stall_state[STALL_IDX];

  // Next-state for the two entries, flush first, then drain/accept ordering.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        // in_ready was low, so no accept can coincide with a skid refill
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = in_pay;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = in_pay;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = in_pay;
        main_valid_d = 1'b1;
      end
    end
    in_ready_d = ~skid_valid_d;
    occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  // State registers; asynchronous reset empties the stage immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign occupancy = occ_q;
  assign {out_aluop, out_addr, out_wd, out_wreg, out_wdata} = main_valid_q ? main_q : Bubble;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf against a queue-based FIFO model.
module tb_pipe_stage_buf;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } pl_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_aluop;
  logic [31:0] in_addr;
  logic [4:0]  in_wd;
  logic        in_wreg;
  logic [31:0] in_wdata;
  logic [5:0]  stall_state;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_aluop;
  logic [31:0] out_addr;
  logic [4:0]  out_wd;
  logic        out_wreg;
  logic [31:0] out_wdata;
  logic [1:0]  occupancy;

  // Wide instance signals
  logic        w_in_valid;
  logic        w_in_ready;
  logic [7:0]  w_in_aluop;
  logic [31:0] w_in_addr;
  logic [5:0]  w_in_wd;
  logic        w_in_wreg;
  logic [63:0] w_in_wdata;
  logic        w_out_valid;
  logic [7:0]  w_out_aluop;
  logic [31:0] w_out_addr;
  logic [5:0]  w_out_wd;
  logic        w_out_wreg;
  logic [63:0] w_out_wdata;
  logic [1:0]  w_occupancy;

  int tests_run = 0;
  int fails     = 0;

  pl_t mq[$];
  pl_t bubble = '0;

  pipe_stage_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_addr(in_addr), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .stall_state(stall_state), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_addr(out_addr), .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .occupancy(occupancy)
  );

  pipe_stage_buf #(.DATA_W(64), .RADDR_W(6)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_aluop(w_in_aluop), .in_addr(w_in_addr), .in_wd(w_in_wd), .in_wreg(w_in_wreg),
    .in_wdata(w_in_wdata), .stall_state(6'd0), .flush(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_aluop(w_out_aluop),
    .out_addr(w_out_addr), .out_wd(w_out_wd), .out_wreg(w_out_wreg),
    .out_wdata(w_out_wdata), .occupancy(w_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pl_t rand_pl();
    pl_t p;
    p.aluop = 8'($urandom);
    p.addr  = $urandom;
    p.wd    = 5'($urandom);
    p.wreg  = 1'($urandom);
    p.wdata = $urandom;
    return p;
  endfunction

  function automatic pl_t out_pl();
    return {out_aluop, out_addr, out_wd, out_wreg, out_wdata};
  endfunction

  task automatic drive(input logic v, input pl_t p);
    in_valid = v;
    {in_aluop, in_addr, in_wd, in_wreg, in_wdata} = p;
  endtask

  // One clock: the model applies FIFO rules to the inputs seen at the edge.
  task automatic tick();
    int  sz;
    bit  acc;
    bit  drn;
    pl_t p;
    sz  = mq.size();
    p   = {in_aluop, in_addr, in_wd, in_wreg, in_wdata};
    acc = in_valid && (sz < 2) && !flush;
    drn = (sz > 0) && out_ready && !stall_state[3];
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    drive(1'b0, '0);
    stall_state = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    w_in_valid = 1'b0;
    {w_in_aluop, w_in_addr, w_in_wd, w_in_wreg, w_in_wdata} = '0;
    rst = 1'b0;
    mq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_pl() !== bubble) begin
      fails++;
      $display("FAIL reset: valid=%b ready=%b occ=%0d pl=%h, want 0 1 0 %h",
               out_valid, in_ready, occupancy, out_pl(), bubble);
    end
  endtask

  task automatic test_single();
    pl_t a;
    a = '{aluop: 8'h12, addr: 32'h1000, wd: 5'd5, wreg: 1'b1, wdata: 32'hDEADBEEF};
    idle_inputs();
    drive(1'b1, a);
    tick();
    drive(1'b0, '0);
    tests_run++;
    if (out_valid !== 1'b1 || out_pl() !== a || occupancy !== 2'd1) begin
      fails++;
      $display("FAIL single: valid=%b occ=%0d pl=%h, want 1 1 %h", out_valid, occupancy, out_pl(), a);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pl() !== bubble) begin
      fails++;
      $display("FAIL single_drain: valid=%b occ=%0d pl=%h, want 0 0 bubble", out_valid, occupancy,
               out_pl());
    end
  endtask

  task automatic test_back_to_back();
    pl_t v[3];
    for (int i = 0; i < 3; i++) v[i] = rand_pl();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, v[i]);
      tick();
    end
    tests_run++;
    if (out_pl() !== v[0] || in_ready !== 1'b0 || occupancy !== 2'd2 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_full: pl=%h ready=%b occ=%0d, want %h 0 2", out_pl(), in_ready, occupancy,
               v[0]);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_pl() !== v[i]) begin
        fails++;
        $display("FAIL b2b_order%0d: valid=%b pl=%h, want 1 %h", i, out_valid, out_pl(), v[i]);
      end
    end
    drive(1'b0, '0);
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_empty: valid=%b occ=%0d ready=%b, want 0 0 1", out_valid, occupancy,
               in_ready);
    end
  endtask

  task automatic test_stall();
    pl_t a;
    pl_t b;
    a = rand_pl();
    b = rand_pl();
    idle_inputs();
    drive(1'b1, a);
    tick();
    out_ready   = 1'b1;
    stall_state = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1'b1, b);
      else drive(1'b0, '0);
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_pl() !== a) begin
        fails++;
        $display("FAIL stall_hold%0d: valid=%b pl=%h, want 1 %h", i, out_valid, out_pl(), a);
      end
    end
    tests_run++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_skid: occ=%0d ready=%b, want 2 0", occupancy, in_ready);
    end
    stall_state = '0;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_pl() !== b) begin
      fails++;
      $display("FAIL stall_release: valid=%b pl=%h, want 1 %h", out_valid, out_pl(), b);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL stall_empty: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    stall_state = 6'b001000;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand_pl());
      tick();
    end
    out_ready = 1'b1;
    flush     = 1'b1;
    drive(1'b1, rand_pl());
    tick();
    tests_run++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_aluop !== 8'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush: occ=%0d valid=%b aluop=%h ready=%b, want 0 0 00 1", occupancy,
               out_valid, out_aluop, in_ready);
    end
    idle_inputs();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      fails++;
      $display("FAIL flush_discard: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_async_reset();
    pl_t a;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand_pl());
      tick();
    end
    drive(1'b0, '0);
    #2 rst = 1'b0;
    #1;
    mq.delete();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_pl() !== bubble) begin
      fails++;
      $display("FAIL async_reset: valid=%b occ=%0d ready=%b pl=%h, want 0 0 1 bubble", out_valid,
               occupancy, in_ready, out_pl());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a = rand_pl();
    drive(1'b1, a);
    tick();
    drive(1'b0, '0);
    tests_run++;
    if (out_valid !== 1'b1 || out_pl() !== a || occupancy !== 2'd1) begin
      fails++;
      $display("FAIL after_reset: valid=%b occ=%0d pl=%h, want 1 1 %h", out_valid, occupancy,
               out_pl(), a);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_wide();
    logic [7:0]  ea = 8'h12;
    logic [31:0] ead = 32'h1000;
    logic [5:0]  ewd = 6'd33;
    logic [63:0] edata = 64'h0123456789ABCDEF;
    w_in_valid = 1'b1;
    {w_in_aluop, w_in_addr, w_in_wd, w_in_wreg, w_in_wdata} = {ea, ead, ewd, 1'b1, edata};
    @(negedge clk);
    w_in_valid = 1'b0;
    tests_run++;
    if (w_out_valid !== 1'b1 || w_out_aluop !== ea || w_out_addr !== ead || w_out_wd !== ewd ||
        w_out_wreg !== 1'b1 || w_out_wdata !== edata || w_occupancy !== 2'd1) begin
      fails++;
      $display("FAIL wide: valid=%b wd=%0d wdata=%h occ=%0d, want 1 33 %h 1", w_out_valid,
               w_out_wd, w_out_wdata, w_occupancy, edata);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    pl_t exp;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), rand_pl());
      out_ready   = ($urandom_range(0, 2) != 0);
      stall_state = 6'($urandom);
      if ($urandom_range(0, 1) == 0) stall_state[3] = 1'b0;
      flush       = ($urandom_range(0, 19) == 0);
      tick();
      exp = (mq.size() > 0) ? mq[0] : bubble;
      tests_run++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          occupancy !== 2'(mq.size()) || out_pl() !== exp) begin
        fails++;
        $display("FAIL random%0d: valid=%b ready=%b occ=%0d pl=%h, want occ=%0d pl=%h", n,
                 out_valid, in_ready, occupancy, out_pl(), mq.size(), exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_wide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
